// File: rtl/fft_frame_buffer_pkg.sv
// Shared definitions for the FFT frame buffer: parameter defaults, FSM state
// encodings and small helpers used by the top and the interface.
package fft_frame_buffer_pkg;

    localparam int FFT_POINT_DEF  = 8192;
    localparam int ADDR_WIDTH_DEF = 14;
    localparam int DATA_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_FILL = 2'd1,
        W_DROP = 2'd2
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_READ = 1'b1
    } rd_state_t;

    function automatic logic [1:0] popcount2(input logic [1:0] v);
        return {v[1] & v[0], v[1] ^ v[0]};
    endfunction

    // Saturating 16-bit increment for the status counters.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/fft_frame_buffer_if.sv
// Stream + status bundle between the filter stage, the frame buffer and the IFFT.
//   i_data/i_valid/i_last : input word stream (no backpressure)
//   o_data/o_valid/o_last : output word stream, i_ready from the IFFT
//   o_drop_cnt/o_err_cnt/o_full_banks : status
// slave = frame buffer side, master = surrounding logic / bench side.
interface fft_frame_buffer_if
    import fft_frame_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
    logic [DATA_WIDTH-1:0] i_data;
    logic                  i_valid;
    logic                  i_last;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_valid;
    logic                  o_last;
    logic                  i_ready;
    logic [15:0]           o_drop_cnt;
    logic [15:0]           o_err_cnt;
    logic [1:0]            o_full_banks;

    modport master (
        output i_data, i_valid, i_last, i_ready,
        input  o_data, o_valid, o_last, o_drop_cnt, o_err_cnt, o_full_banks
    );

    modport slave (
        input  i_data, i_valid, i_last, i_ready,
        output o_data, o_valid, o_last, o_drop_cnt, o_err_cnt, o_full_banks
    );
endinterface

// File: rtl/fft_buf_ram.sv
// Simple dual-port RAM: one write port, one read port with a 1-cycle
// registered read. 2^ADDR_WIDTH words of DATA_WIDTH bits.
//   we/waddr/wdata : write port
//   re/raddr/rdata : read port, rdata valid the cycle after re
module fft_buf_ram
    import fft_frame_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/fft_frame_buffer.sv
// Ping-pong frame buffer between the spectral filter and the IFFT.
// Complete FFT_POINT-word frames are written into one of two RAM banks and
// streamed out in arrival order; frames with a bad length or with no free
// bank are discarded and counted.
//   clk, rst : clock, synchronous active-high reset
//   bus      : stream/status bundle (slave modport)
module fft_frame_buffer
    import fft_frame_buffer_pkg::*;
#(
    parameter int FFT_POINT  = FFT_POINT_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input logic               clk,
    input logic               rst,
    fft_frame_buffer_if.slave bus
);
    localparam int OW = ADDR_WIDTH - 1;
    localparam logic [OW-1:0]         LAST_OFF = OW'(FFT_POINT - 1);
    localparam logic [ADDR_WIDTH-1:0] NPTS     = ADDR_WIDTH'(FFT_POINT);

    // write side
    wr_state_t             wr_state, wr_state_n;
    logic                  wr_bank, wr_bank_n;
    logic [OW-1:0]         wr_off, wr_off_n;
    logic                  ram_we, drop_inc, err_inc;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic [1:0]            full, full_n, set_full, clr_full, full_banks;
    logic [15:0]           drop_cnt, err_cnt;

    // read side
    rd_state_t             rd_state, rd_state_n;
    logic                  rd_bank, rd_issue, rd_done, issue_last;
    logic [ADDR_WIDTH-1:0] rd_off;      // next offset to fetch, reaches FFT_POINT
    logic [OW-1:0]         fetch_off;
    logic                  rd_pend, rd_pend_last; // RAM output valid this cycle
    logic [DATA_WIDTH-1:0] ram_rdata;

    // two-entry output queue; entry 0 drives the output port
    logic [1:0]            q_cnt, occ;
    logic [DATA_WIDTH-1:0] q_data0, q_data1;
    logic                  q_last0, q_last1;
    logic                  pop, credit;

    always_comb begin
        wr_state_n = wr_state;
        wr_bank_n  = wr_bank;
        wr_off_n   = wr_off;
        set_full   = '0;
        drop_inc   = 1'b0;
        err_inc    = 1'b0;
        ram_we     = 1'b0;
        ram_waddr  = {wr_bank, wr_off};
        unique case (wr_state)
            W_IDLE: if (bus.i_valid) begin
                if (!full[wr_bank]) begin
                    ram_we    = 1'b1;
                    ram_waddr = {wr_bank, {OW{1'b0}}};
                    // a one-word frame is short by definition
                    if (bus.i_last) err_inc = 1'b1;
                    else begin
                        wr_state_n = W_FILL;
                        wr_off_n   = OW'(1);
                    end
                end else begin
                    drop_inc = 1'b1;
                    if (!bus.i_last) wr_state_n = W_DROP;
                end
            end
            W_FILL: if (bus.i_valid) begin
                ram_we = 1'b1;
                if (wr_off == LAST_OFF) begin
                    if (bus.i_last) begin
                        set_full[wr_bank] = 1'b1;
                        wr_bank_n         = ~wr_bank;
                        wr_state_n        = W_IDLE;
                    end else begin
                        err_inc    = 1'b1;
                        wr_state_n = W_DROP;
                    end
                end else if (bus.i_last) begin
                    err_inc    = 1'b1;
                    wr_state_n = W_IDLE;
                end else begin
                    wr_off_n = wr_off + 1'b1;
                end
            end
            W_DROP: if (bus.i_valid && bus.i_last) wr_state_n = W_IDLE;
            default: wr_state_n = W_IDLE;
        endcase
    end

    // A fetch is allowed only if its data will still fit in the queue even
    // when nothing is popped next cycle; this keeps one word per cycle flowing
    // with a single prefetch in flight.
    assign pop    = (q_cnt != 2'd0) && bus.i_ready;
    assign occ    = q_cnt + {1'b0, rd_pend} - {1'b0, pop};
    assign credit = (occ < 2'd2);

    always_comb begin
        rd_state_n = rd_state;
        rd_issue   = 1'b0;
        clr_full   = '0;
        rd_done    = pop && q_last0;
        fetch_off  = (rd_state == R_IDLE) ? {OW{1'b0}} : rd_off[OW-1:0];
        issue_last = (fetch_off == LAST_OFF);
        unique case (rd_state)
            // word 0 is fetched on the same cycle the full bank is seen
            R_IDLE: if (full[rd_bank] && credit) begin
                rd_issue   = 1'b1;
                rd_state_n = R_READ;
            end
            R_READ: begin
                if (rd_off != NPTS && credit) rd_issue = 1'b1;
                if (rd_done) begin
                    clr_full[rd_bank] = 1'b1;
                    rd_state_n        = R_IDLE;
                end
            end
        endcase
    end

    assign full_n = (full | set_full) & ~clr_full;

    fft_buf_ram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (bus.i_data),
        .re    (rd_issue),
        .raddr ({rd_bank, fetch_off}),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state   <= W_IDLE;
            wr_bank    <= 1'b0;
            wr_off     <= '0;
            full       <= '0;
            full_banks <= '0;
            drop_cnt   <= '0;
            err_cnt    <= '0;
        end else begin
            wr_state   <= wr_state_n;
            wr_bank    <= wr_bank_n;
            wr_off     <= wr_off_n;
            full       <= full_n;
            full_banks <= popcount2(full_n);
            if (drop_inc) drop_cnt <= sat_inc(drop_cnt);
            if (err_inc)  err_cnt  <= sat_inc(err_cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state     <= R_IDLE;
            rd_bank      <= 1'b0;
            rd_off       <= '0;
            rd_pend      <= 1'b0;
            rd_pend_last <= 1'b0;
            q_cnt        <= '0;
            q_data0      <= '0;
            q_data1      <= '0;
            q_last0      <= 1'b0;
            q_last1      <= 1'b0;
        end else begin
            rd_state     <= rd_state_n;
            rd_pend      <= rd_issue;
            rd_pend_last <= issue_last;
            if (rd_done)  rd_bank <= ~rd_bank;
            if (rd_issue) rd_off  <= {1'b0, fetch_off} + 1'b1;
            unique case ({rd_pend, pop})
                2'b01: begin
                    q_cnt   <= q_cnt - 2'd1;
                    q_data0 <= q_data1;
                    q_last0 <= q_last1;
                end
                2'b10: begin
                    q_cnt <= q_cnt + 2'd1;
                    if (q_cnt == 2'd0) begin
                        q_data0 <= ram_rdata;
                        q_last0 <= rd_pend_last;
                    end else begin
                        q_data1 <= ram_rdata;
                        q_last1 <= rd_pend_last;
                    end
                end
                2'b11: begin
                    if (q_cnt == 2'd1) begin
                        q_data0 <= ram_rdata;
                        q_last0 <= rd_pend_last;
                    end else begin
                        q_data0 <= q_data1;
                        q_last0 <= q_last1;
                        q_data1 <= ram_rdata;
                        q_last1 <= rd_pend_last;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_data       = q_data0;
    assign bus.o_valid      = (q_cnt != 2'd0);
    assign bus.o_last       = q_last0 && (q_cnt != 2'd0);
    assign bus.o_drop_cnt   = drop_cnt;
    assign bus.o_err_cnt    = err_cnt;
    assign bus.o_full_banks = full_banks;
endmodule

// File: tb/tb_fft_frame_buffer.sv
module tb_fft_frame_buffer;
    localparam int NPT = 8;
    localparam int AW  = 4;
    localparam int DW  = 32;
    localparam int M_WAIT = 0, M_COLLECT = 1, M_DISCARD = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fft_frame_buffer_if #(.DATA_WIDTH(DW)) bus();

    fft_frame_buffer #(.FFT_POINT(NPT), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct packed { logic last; logic [DW-1:0] data; } ow_t;
    ow_t             exp_q[$];     // words the IFFT must still receive, in order
    logic [DW-1:0]   cur_q[$];     // words of the frame currently arriving
    int              mode = M_WAIT;
    int              slots = 0;    // frames held in the buffer (incl. one being read)
    int              exp_drop = 0, exp_err = 0, exp_pushed = 0;
    bit              prev_stall = 0, prev_mid = 0, just_rst = 0, lat_arm = 0;
    int              lat_n = 0;
    logic [DW:0]     prev_w;
    int              s0, freed, done_f;
    ow_t             w;
    int              cyc = 0;
    logic [DW-1:0]   cap_data[$];
    logic            cap_last[$];
    int              cap_cyc[$];

    always @(negedge clk) begin
        cyc++;
        if (just_rst) begin
            chk("rst_o_data",  64'(bus.o_data), 64'd0);
            chk("rst_o_valid", 64'(bus.o_valid), 64'd0);
            chk("rst_o_last",  64'(bus.o_last), 64'd0);
        end
        chk("drop_cnt",   64'(bus.o_drop_cnt), 64'(exp_drop));
        chk("err_cnt",    64'(bus.o_err_cnt), 64'(exp_err));
        chk("full_banks", 64'(bus.o_full_banks), 64'(slots));
        if (prev_stall) begin
            chk("stall_valid", 64'(bus.o_valid), 64'd1);
            chk("stall_word",  64'({bus.o_last, bus.o_data}), 64'(prev_w));
        end
        if (prev_mid) chk("no_bubble", 64'(bus.o_valid), 64'd1);
        if (bus.o_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL spurious_valid: got o_valid=1 data=%0h, required no output", bus.o_data);
            end else begin
                chk("o_word", 64'({bus.o_last, bus.o_data}), 64'(exp_q[0]));
            end
        end
        if (lat_arm) begin
            lat_n++;
            if (bus.o_valid || lat_n >= 3) begin
                chk("first_word_latency", 64'(bus.o_valid), 64'd1);
                lat_arm = 0;
            end
        end

        // advance the model across the coming rising edge
        prev_stall = 0; prev_mid = 0; just_rst = 0;
        if (rst) begin
            exp_q.delete(); cur_q.delete();
            mode = M_WAIT; slots = 0; exp_drop = 0; exp_err = 0;
            lat_arm = 0; just_rst = 1;
        end else begin
            s0 = slots; freed = 0; done_f = 0;
            if (bus.o_valid && bus.i_ready) begin
                cap_data.push_back(bus.o_data);
                cap_last.push_back(bus.o_last);
                cap_cyc.push_back(cyc);
                if (exp_q.size() > 0) begin
                    w = exp_q.pop_front();
                    if (w.last) freed = 1; else prev_mid = 1;
                end
            end
            prev_stall = bus.o_valid && !bus.i_ready;
            prev_w = {bus.o_last, bus.o_data};
            if (bus.i_valid) begin
                case (mode)
                    M_WAIT: begin
                        if (s0 < 2) begin
                            cur_q.delete();
                            cur_q.push_back(bus.i_data);
                            if (bus.i_last) exp_err = (exp_err < 65535) ? exp_err + 1 : exp_err;
                            else mode = M_COLLECT;
                        end else begin
                            exp_drop = (exp_drop < 65535) ? exp_drop + 1 : exp_drop;
                            if (!bus.i_last) mode = M_DISCARD;
                        end
                    end
                    M_COLLECT: begin
                        cur_q.push_back(bus.i_data);
                        if (cur_q.size() == NPT) begin
                            if (bus.i_last) begin done_f = 1; mode = M_WAIT; end
                            else begin
                                exp_err = (exp_err < 65535) ? exp_err + 1 : exp_err;
                                mode = M_DISCARD;
                            end
                        end else if (bus.i_last) begin
                            exp_err = (exp_err < 65535) ? exp_err + 1 : exp_err;
                            mode = M_WAIT;
                        end
                    end
                    default: if (bus.i_last) mode = M_WAIT;
                endcase
            end
            if (done_f != 0) begin
                if (exp_q.size() == 0) begin lat_arm = 1; lat_n = 0; end
                for (int k = 0; k < NPT; k++) begin
                    w.last = (k == NPT - 1);
                    w.data = cur_q[k];
                    exp_q.push_back(w);
                end
                exp_pushed += NPT;
            end
            slots = slots + done_f - freed;
        end
    end

    // ---------------- ready driver ----------------
    bit rdy_rand = 0;
    bit rdy_val  = 1;
    always @(posedge clk) begin
        #1;
        bus.i_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input logic [DW-1:0] base, input int len, input bit rnd);
        for (int i = 0; i < len; i++) begin
            bus.i_valid = 1'b1;
            bus.i_data  = rnd ? DW'($urandom) : base + DW'(i);
            bus.i_last  = (i == len - 1);
            tick();
        end
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
        cap_data.delete(); cap_last.delete(); cap_cyc.delete();
        exp_pushed = 0;
    endtask

    task automatic wait_idle(input int maxc);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mode != M_WAIT || bus.o_valid) && n < maxc) begin
            tick(); n++;
        end
        if (n >= maxc) begin
            n_cmp++; n_err++;
            $display("FAIL drain_timeout: got %0d words pending, required 0", exp_q.size());
        end
        repeat (4) tick();
    endtask

    task automatic chk_cap(input string nm, input logic [DW-1:0] base, input int idx0);
        for (int i = 0; i < NPT; i++) begin
            chk(nm, 64'(cap_data[idx0 + i]), 64'(base + DW'(i)));
            chk({nm, "_last"}, 64'(cap_last[idx0 + i]), 64'(i == NPT - 1));
        end
    endtask

    initial begin
        int len, r, n;
        bus.i_valid = 1'b0; bus.i_last = 1'b0; bus.i_data = '0;
        repeat (3) tick();
        do_reset();
        chk("reset_full_banks", 64'(bus.o_full_banks), 64'd0);
        chk("reset_drop_cnt",   64'(bus.o_drop_cnt), 64'd0);
        chk("reset_o_valid",    64'(bus.o_valid), 64'd0);

        // single frame, ready high
        send_frame(0, NPT, 0);
        wait_idle(100);
        chk("s1_words", 64'(cap_data.size()), 64'd8);
        if (cap_data.size() == NPT) begin
            chk_cap("s1_data", 0, 0);
            chk("s1_consecutive", 64'(cap_cyc[NPT-1] - cap_cyc[0]), 64'(NPT - 1));
        end

        // three back-to-back frames while the IFFT is stalled
        do_reset();
        rdy_val = 0;
        repeat (2) tick();
        send_frame(32'h100, NPT, 0);
        send_frame(32'h200, NPT, 0);
        send_frame(32'h300, NPT, 0);
        repeat (12) tick();
        chk("s2_full_banks", 64'(bus.o_full_banks), 64'd2);
        chk("s2_drop_cnt",   64'(bus.o_drop_cnt), 64'd1);
        chk("s2_no_output",  64'(cap_data.size()), 64'd0);
        rdy_val = 1;
        wait_idle(200);
        chk("s2_words", 64'(cap_data.size()), 64'd16);
        if (cap_data.size() == 2 * NPT) begin
            chk_cap("s2_frame1", 32'h100, 0);
            chk_cap("s2_frame2", 32'h200, NPT);
        end
        chk("s2_full_after", 64'(bus.o_full_banks), 64'd0);

        // short frame then a good one
        do_reset();
        send_frame(32'h300, 6, 0);
        repeat (6) tick();
        chk("s3_err_cnt", 64'(bus.o_err_cnt), 64'd1);
        chk("s3_no_output", 64'(cap_data.size()), 64'd0);
        send_frame(32'h400, NPT, 0);
        wait_idle(100);
        chk("s3_words", 64'(cap_data.size()), 64'd8);
        if (cap_data.size() == NPT) chk_cap("s3_data", 32'h400, 0);

        // long frame then a good one
        do_reset();
        send_frame(32'h500, 10, 0);
        repeat (6) tick();
        chk("s4_err_cnt", 64'(bus.o_err_cnt), 64'd1);
        chk("s4_no_output", 64'(cap_data.size()), 64'd0);
        send_frame(32'h600, NPT, 0);
        wait_idle(100);
        chk("s4_words", 64'(cap_data.size()), 64'd8);
        if (cap_data.size() == NPT) chk_cap("s4_data", 32'h600, 0);

        // random frames, random gaps, random ready
        do_reset();
        rdy_rand = 1;
        for (int f = 0; f < 24; f++) begin
            r = $urandom_range(0, 9);
            len = (r < 7) ? NPT : (r == 7) ? $urandom_range(2, NPT - 1) : $urandom_range(NPT + 1, NPT + 3);
            send_frame(0, len, 1);
            n = $urandom_range(0, 12);
            repeat (n) tick();
        end
        wait_idle(2000);
        chk("s5_word_count", 64'(cap_data.size()), 64'(exp_pushed));
        rdy_rand = 0;
        repeat (2) tick();

        // reset in the middle of an input frame
        for (int i = 0; i < 4; i++) begin
            bus.i_valid = 1'b1; bus.i_data = 32'h700 + i; bus.i_last = 1'b0;
            tick();
        end
        do_reset();
        send_frame(32'h800, NPT, 0);
        wait_idle(100);
        chk("s6a_words", 64'(cap_data.size()), 64'd8);
        if (cap_data.size() == NPT) chk_cap("s6a_data", 32'h800, 0);

        // reset in the middle of an output frame
        cap_data.delete(); cap_last.delete(); cap_cyc.delete();
        send_frame(32'h900, NPT, 0);
        n = 0;
        while (cap_data.size() < 3 && n < 50) begin tick(); n++; end
        if (n >= 50) begin
            n_cmp++; n_err++;
            $display("FAIL s6b_output_timeout: got %0d words, required 3", cap_data.size());
        end
        do_reset();
        chk("s6b_valid_after_rst", 64'(bus.o_valid), 64'd0);
        chk("s6b_full_after_rst",  64'(bus.o_full_banks), 64'd0);
        send_frame(32'hA00, NPT, 0);
        wait_idle(100);
        chk("s6b_words", 64'(cap_data.size()), 64'd8);
        if (cap_data.size() == NPT) chk_cap("s6b_data", 32'hA00, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
